// File: rtl/dds_pkg.sv
// Shared constants, FSM state type and threshold helper for the DDS frequency meter.
// Thresholds are computed in 9 bits so large hysteresis values saturate instead of wrapping.
package dds_pkg;

  localparam logic [7:0] MID = 8'd128;

  typedef enum logic {
    SEEK = 1'b0,
    MEAS = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } thr_t;

  function automatic thr_t calc_thr(input logic [7:0] hyst);
    logic [8:0] hi_s;
    logic [8:0] lo_s;
    thr_t       t;
    hi_s = {1'b0, MID} + {1'b0, hyst};
    lo_s = {1'b0, MID} - {1'b0, hyst};
    t.hi = hi_s[8] ? 8'd255 : hi_s[7:0];
    t.lo = lo_s[8] ? 8'd0 : lo_s[7:0];
    return t;
  endfunction

endpackage

// File: rtl/dds_freq_meter_cross.sv
// Input register, hysteresis comparator and registered rising-crossing pulse.
// The pulse is aligned with the cycle in which the comparator level first reads 1.
module dds_cross_det
  import dds_pkg::*;
#(
  parameter logic [7:0] HYST = 8'd16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic [7:0] s_q,
  output logic       rise
);

  localparam thr_t THR = calc_thr(HYST);

  logic lvl_r;
  logic lvl_next_s;

  // Hysteresis decision on the registered sample; set wins if thresholds coincide
  always_comb begin
    lvl_next_s = lvl_r;
    if (s_q >= THR.hi) begin
      lvl_next_s = 1'b1;
    end else if (s_q <= THR.lo) begin
      lvl_next_s = 1'b0;
    end else begin
      lvl_next_s = lvl_r;
    end
  end

  // Sample register, comparator level and rising-edge pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_q   <= 8'd0;
      lvl_r <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s_q <= data_in;
      if (en) begin
        lvl_r <= lvl_next_s;
        rise  <= lvl_next_s & ~lvl_r;
      end else begin
        lvl_r <= 1'b0;
        rise  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dds_freq_meter.sv
// Tone meter: counts clock cycles over 2^AVG_LOG2 rising crossings and reports the
// peak-to-peak amplitude of the same window, with a timeout-driven no-signal flag.
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter logic [7:0]  HYST     = 8'd16,
  parameter int          AVG_LOG2 = 4,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] TIMEOUT  = 32'd50_000_000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [7:0]       data_in,
  output logic [CNT_W-1:0] period_sum,
  output logic [7:0]       vpp,
  output logic             meas_valid,
  output logic             no_signal
);

  localparam logic [8:0]  NWIN    = 9'd1 << AVG_LOG2;
  localparam logic [63:0] TO_LAST = 64'(TIMEOUT) - 64'd1;

  logic [7:0]       s_q_s;
  logic             rise_s;
  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n, cnt_inc_s, psum_n;
  logic [8:0]       ncross_r, ncross_n;
  logic [7:0]       min_r, min_n, max_r, max_n, vpp_n;
  logic             valid_n, nosig_n, timeout_s;

  dds_cross_det #(.HYST(HYST)) u_cross (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .data_in (data_in),
    .s_q     (s_q_s),
    .rise    (rise_s)
  );

  // Saturating increment keeps the counter from wrapping when TIMEOUT exceeds its range
  assign cnt_inc_s = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1'b1);
  assign timeout_s = (64'(cnt_r) == TO_LAST);

  // Next-state and output decode; a rise always takes precedence over a timeout
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_inc_s;
    ncross_n = ncross_r;
    min_n    = min_r;
    max_n    = max_r;
    psum_n   = period_sum;
    vpp_n    = vpp;
    valid_n  = 1'b0;
    nosig_n  = no_signal;
    if (!en) begin
      state_n  = SEEK;
      cnt_n    = '0;
      ncross_n = 9'd0;
      min_n    = 8'd255;
      max_n    = 8'd0;
    end else begin
      case (state_r)
        SEEK: begin
          min_n = 8'd255;
          max_n = 8'd0;
          if (rise_s) begin
            state_n  = MEAS;
            cnt_n    = '0;
            ncross_n = 9'd0;
            min_n    = s_q_s;
            max_n    = s_q_s;
          end else if (timeout_s) begin
            cnt_n   = '0;
            nosig_n = 1'b1;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end
        MEAS: begin
          min_n = (s_q_s < min_r) ? s_q_s : min_r;
          max_n = (s_q_s > max_r) ? s_q_s : max_r;
          if (rise_s) begin
            if ((ncross_r + 9'd1) == NWIN) begin
              psum_n   = cnt_inc_s;
              vpp_n    = max_r - min_r;
              valid_n  = 1'b1;
              nosig_n  = 1'b0;
              cnt_n    = '0;
              ncross_n = 9'd0;
              min_n    = s_q_s;
              max_n    = s_q_s;
            end else begin
              ncross_n = ncross_r + 9'd1;
            end
          end else if (timeout_s) begin
            state_n = SEEK;
            cnt_n   = '0;
            nosig_n = 1'b1;
            min_n   = 8'd255;
            max_n   = 8'd0;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end
        default: begin
          state_n  = SEEK;
          cnt_n    = '0;
          ncross_n = 9'd0;
        end
      endcase
    end
  end

  // State, counters, extrema and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= SEEK;
      cnt_r      <= '0;
      ncross_r   <= 9'd0;
      min_r      <= 8'd255;
      max_r      <= 8'd0;
      period_sum <= '0;
      vpp        <= 8'd0;
      meas_valid <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      ncross_r   <= ncross_n;
      min_r      <= min_n;
      max_r      <= max_n;
      period_sum <= psum_n;
      vpp        <= vpp_n;
      meas_valid <= valid_n;
      no_signal  <= nosig_n;
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter with AVG_LOG2=2 and TIMEOUT=1000; expected
// measurements are queued when stimulus starts and popped on each meas_valid pulse.
module tb_dds_freq_meter;

  localparam int P      = 100;
  localparam int WINDOW = 400;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [7:0]  data_in;
  logic [31:0] period_sum;
  logic [7:0]  vpp;
  logic        meas_valid;
  logic        no_signal;

  always #5 clk = ~clk;

  dds_freq_meter #(
    .HYST     (8'd16),
    .AVG_LOG2 (2),
    .CNT_W    (32),
    .TIMEOUT  (32'd1000)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .data_in    (data_in),
    .period_sum (period_sum),
    .vpp        (vpp),
    .meas_valid (meas_valid),
    .no_signal  (no_signal)
  );

  typedef struct {
    logic [31:0] psum;
    logic [7:0]  vlo;
    logic [7:0]  vhi;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_pulse = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] psum, input logic [7:0] vlo, input logic [7:0] vhi,
                      input int gap);
    exp_t e;
    e.psum = psum;
    e.vlo  = vlo;
    e.vhi  = vhi;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  // One clock: drive after the edge, sample on the falling edge, score any pulse
  task automatic step(input logic [7:0] d);
    exp_t e;
    @(posedge clk);
    #1 data_in = d;
    cyc++;
    @(negedge clk);
    if (meas_valid === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_pulse observed=pulse at cycle %0d expected=no pulse", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("period_sum", 64'(period_sum), 64'(e.psum));
        total++;
        assert (vpp >= e.vlo && vpp <= e.vhi) else begin
          bad++;
          $error("FAIL vpp observed=%0d expected=%0d..%0d", vpp, e.vlo, e.vhi);
        end
        check("no_signal_at_pulse", 64'(no_signal), 64'd0);
        if (e.gap != 0) check("pulse_gap", 64'(cyc - last_pulse), 64'(e.gap));
      end
      last_pulse = cyc;
    end
  endtask

  task automatic square(input int periods);
    for (int p = 0; p < periods; p++)
      for (int i = 0; i < P; i++) step((i < P / 2) ? 8'd216 : 8'd40);
  endtask

  task automatic sine(input int periods);
    real r;
    for (int p = 0; p < periods; p++)
      for (int i = 0; i < P; i++) begin
        r = 127.5 + 127.5 * $sin(2.0 * 3.141592653589793 * real'(i) / real'(P));
        if (r < 0.0) r = 0.0;
        if (r > 255.0) r = 255.0;
        step(8'($rtoi(r + 0.5)));
      end
  endtask

  task automatic hold(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) step(d);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #1;
    check("rst_period_sum", 64'(period_sum), 64'd0);
    check("rst_vpp", 64'(vpp), 64'd0);
    check("rst_meas_valid", 64'(meas_valid), 64'd0);
    check("rst_no_signal", 64'(no_signal), 64'd0);
    hold(8'd40, 3);
    rstn = 1'b1;
  endtask

  initial begin
    rstn    = 1'b1;
    en      = 1'b1;
    data_in = 8'd128;
    #2;
    apply_reset();

    // Oscillation inside the hysteresis band: timeout lands exactly 1000 cycles after SEEK entry
    for (int i = 0; i < 999; i++) step((i % 2 == 0) ? 8'd120 : 8'd136);
    check("no_signal_before_timeout", 64'(no_signal), 64'd0);
    step(8'd120);
    check("no_signal_at_timeout", 64'(no_signal), 64'd1);

    // Square 40/216 from SEEK: first result after 5 crossings, then every 400 cycles
    push(32'(WINDOW), 8'd176, 8'd176, 0);
    push(32'(WINDOW), 8'd176, 8'd176, WINDOW);
    square(4);
    check("no_signal_held_before_result", 64'(no_signal), 64'd1);
    check("pending_after_4_periods", 64'(sb.size()), 64'd2);
    square(5);
    check("pending_after_square", 64'(sb.size()), 64'd0);

    // Signal lost at mid-scale: timeout asserts no_signal, results hold
    hold(8'd128, 1100);
    check("no_signal_after_loss", 64'(no_signal), 64'd1);
    check("held_period_sum", 64'(period_sum), 64'(WINDOW));
    check("held_vpp", 64'(vpp), 64'd176);

    // Full-scale sine resumes; no_signal clears with the first new result
    push(32'(WINDOW), 8'd254, 8'd255, 0);
    push(32'(WINDOW), 8'd254, 8'd255, WINDOW);
    sine(9);
    check("pending_after_sine", 64'(sb.size()), 64'd0);
    check("no_signal_after_sine", 64'(no_signal), 64'd0);

    // Reset in the middle of a window; next result uses only post-reset crossings
    square(2);
    apply_reset();
    push(32'(WINDOW), 8'd176, 8'd176, 0);
    push(32'(WINDOW), 8'd176, 8'd176, WINDOW);
    square(9);
    check("pending_after_reset", 64'(sb.size()), 64'd0);

    // Enable dropped mid-window for 50 cycles: outputs hold, measurement restarts
    square(2);
    en = 1'b0;
    hold(8'd40, 50);
    check("en_low_period_sum", 64'(period_sum), 64'(WINDOW));
    check("en_low_vpp", 64'(vpp), 64'd176);
    check("en_low_no_signal", 64'(no_signal), 64'd0);
    en = 1'b1;
    push(32'(WINDOW), 8'd176, 8'd176, 0);
    push(32'(WINDOW), 8'd176, 8'd176, WINDOW);
    square(9);
    check("pending_at_end", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_freq_meter.md
# dds_freq_meter

Measurement-side counterpart to the DDS sample generator. It accepts the 8-bit offset-binary sample stream a DDS produces and detects rising mid-scale crossings with hysteresis. It accumulates the clock-cycle count over 2^AVG_LOG2 signal periods and tracks peak-to-peak amplitude. Used in loopback to check frequency-word and ROM-table correctness on hardware, and as a standalone tone meter.

## Interface
- `HYST`, default 8'd16: hysteresis half-width around mid-scale 128.
- `AVG_LOG2`, default 4: number of periods averaged is 2^AVG_LOG2, legal range 0..8.
- `CNT_W`, default 32: width of the cycle counter and of `period_sum`.
- `TIMEOUT`, default 32'd50_000_000: cycles without a rising crossing before `no_signal` asserts.
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `en`  in  1: measurement enable; low holds the block idle.
- `data_in`  in  8: unsigned sample, mid-scale 128.
- `period_sum`  out  CNT_W: clk cycles spanning 2^AVG_LOG2 periods. Reset value 0.
- `vpp`  out  8: max − min sample seen over the same window. Reset value 0.
- `meas_valid`  out  1: one-cycle pulse when `period_sum`/`vpp` update. Reset value 0.
- `no_signal`  out  1: level; timeout occurred with no completed measurement since. Reset value 0.

## Operation
- **Input stage:** `data_in` is registered once into `s_q`.
- **Comparator state `lvl`:**
  - Set to 1 when `s_q >= 128+HYST`.
  - Cleared to 0 when `s_q <= 128-HYST`.
  - Otherwise holds its value.
  - Reset value 0.
  - Compute the thresholds in 9 bits, saturating to 0..255.
- **Rising event `rise`:** `lvl` transitions 0→1. Registered, one cycle.
- **FSM states:** SEEK, MEAS.
- **SEEK:**
  - `cnt` counts idle cycles.
  - `min` is preset to 255 and `max` to 0.
  - On `rise`: `cnt` ← 0, `ncross` ← 0, `min`/`max` are seeded with the current `s_q`, go to MEAS.
- **MEAS:**
  - `cnt` increments every cycle.
  - `min`/`max` update every cycle from `s_q`.
  - On each `rise`, `ncross` increments.
  - When `ncross` reaches 2^AVG_LOG2 on a `rise`:
    - `period_sum` ← `cnt`+1.
    - `vpp` ← `max`−`min`.
    - `meas_valid` pulses.
    - `no_signal` ← 0.
    - Restart seamlessly: `cnt` ← 0, `ncross` ← 0, extrema reseeded from `s_q`. Stay in MEAS.
- **Timeout:**
  - In either state, if `cnt` reaches TIMEOUT−1 with no `rise`, assert `no_signal` and go to SEEK with `cnt` ← 0.
  - `cnt` never wraps. It saturates at all-ones if TIMEOUT exceeds 2^CNT_W.
- **Simultaneous events:** `rise` in the same cycle as timeout is treated as `rise`; the timeout is ignored.
- **`en` low:**
  - Synchronously forces SEEK and clears `cnt`, `ncross` and `lvl`.
  - Outputs hold their last values. `meas_valid` is 0.
- **Reset mid-measurement:** all state, and every output, returns to its reset value immediately; there is no partial result.

## Timing
- **Latency:** the sample that first satisfies `>= 128+HYST` is presented at `data_in` in cycle t. `rise` is high in t+2. `meas_valid` is high in t+3 when that crossing completes a window.
- **`period_sum` / `vpp`:** change only in the `meas_valid` cycle and are stable in that cycle.
- **Steady state:** for a periodic input of P cycles, `period_sum` = P·2^AVG_LOG2 exactly, and successive `meas_valid` pulses are P·2^AVG_LOG2 cycles apart.
- **First result:** arrives after 2^AVG_LOG2 + 1 rising crossings following SEEK entry.
- **`no_signal`:** asserts in the cycle the FSM returns to SEEK on timeout. It deasserts together with the next `meas_valid`.

## Structure
- Package `dds_pkg` holds:
  - `MID` = 8'd128.
  - FSM state typedef {SEEK, MEAS}.
  - A function computing the saturated thresholds.
- Sub-module `dds_cross_det` contains the input register, the hysteresis comparator and `rise` generation (parameter HYST).
- Top level holds the FSM, counter, crossing counter, min/max tracking and output registers.

## Test plan
- Ideal square wave 40/216, period 100, AVG_LOG2=2 → `period_sum`=400, `vpp`=176, pulses every 400 cycles after the first.
- Sine from DDS ROM at 8-bit full scale, period 1000, defaults → `period_sum`=16000, `vpp`=255±1.
- Input oscillating 120..136 (inside hysteresis 16) with TIMEOUT=1000 → no `meas_valid`; `no_signal` rises at cycle 1000 after SEEK entry and repeats its timeout every 1000 cycles.
- Square period 100, then held at 128, then resumed → `no_signal` sets after TIMEOUT; it clears on the first `meas_valid` after 2^AVG_LOG2+1 new crossings.
- Assert `rstn` low mid-window, release → all outputs 0; the next `period_sum` counts only post-reset crossings and equals P·2^AVG_LOG2.
- `en` dropped mid-window for 50 cycles → no pulse, outputs held, measurement restarts from SEEK with a correct value.
